surf_cmd_receiver: RTL and testbench
====================================

// Module: surf_cmd_receiver
// PURPOSE
//  SURF-side decoder for the per-SURF serial CMD line driven by the TURF event generator.
//  Deframes one bit per clk33 cycle into type, buffer and event ID fields.
//  Checks parity and stop bit, then presents each good command to local digitize and clear
//  logic over a valid/ack handshake.
//  Sits between the CMD input pin and the SURF digitizer/readout sequencer.
// PARAMETERS
//  BUF_BITS   2   width of buffer field
//  EVID_BITS  32  width of event ID field
//  Frame length FLEN = 1+2+BUF_BITS+EVID_BITS+1+1 = 39 bits at defaults.
// PORTS
//  clk33_i       in   1          33 MHz clock; CMD is sampled on the rising edge
//  rst_n_i       in   1          asynchronous active-low reset
//  CMD_i         in   1          serial command line from TURF; idle low
//  cmd_ack_i     in   1          consumer accepts pending command
//  cmd_valid_o   out  1          command pending; held until acked
//  cmd_type_o    out  2          00 DIGITIZE, 01 CLEAR, 10 EVID_RESET, 11 reserved
//  cmd_buffer_o  out  BUF_BITS   buffer number
//  cmd_evid_o    out  EVID_BITS  event ID
//  parity_err_o  out  1          1-cycle pulse: frame dropped for bad parity
//  frame_err_o   out  1          1-cycle pulse: frame dropped for bad stop bit
//  overrun_o     out  1          1-cycle pulse: good frame dropped, previous still pending
//  busy_o        out  1          FSM not in IDLE
// BEHAVIOUR
//  - Frame format, MSB first: start(1), type[1:0], buffer, evid, parity, stop(0).
//  - Parity is even over type, buffer, evid and the parity bit: the XOR of all of them is 0.
//  - CMD_i is always registered once into cmd_q. All decoding uses cmd_q.
//  - Reset: all outputs 0, shift register 0, bit counter 0, FSM enters WAIT_LOW.
//    This prevents a frame that was cut by reset from decoding as a start bit.
//  - FSM states:
//    - WAIT_LOW: go to IDLE when cmd_q==0.
//    - IDLE: cmd_q==1 is the start bit; clear the bit counter; go to SHIFT.
//    - SHIFT: shift cmd_q into the shift register; after 2+BUF_BITS+EVID_BITS+1 bits, go to STOP.
//    - STOP: sample the stop bit.
//      - cmd_q==1: pulse frame_err_o; go to WAIT_LOW.
//      - cmd_q==0 and parity fails: pulse parity_err_o; go to IDLE.
//      - cmd_q==0 and parity good: deliver the frame; go to IDLE.
//  - Back-to-back frames: a start bit may follow the stop bit on the very next cycle.
//    IDLE must accept it with no gap cycle. Deliver happens in the STOP cycle, so IDLE is
//    entered in time.
//  - Deliver:
//    - cmd_valid_o==0, or cmd_ack_i==1 this cycle: load the fields and set cmd_valid_o next cycle.
//    - Otherwise: pulse overrun_o; keep the pending fields; drop the new frame.
//  - Error priority: frame_err_o takes priority over parity_err_o; only one pulses per frame.
//  - Handshake:
//    - cmd_valid_o clears on the cycle after cmd_ack_i is seen high, unless a new frame is
//      delivered in that same cycle.
//    - Fields are stable while cmd_valid_o is high.
//    - cmd_ack_i while cmd_valid_o==0 is ignored.
//  - Latency: the stop bit at CMD_i on edge N is in cmd_q at edge N+1.
//    STOP evaluates at N+1; cmd_valid_o is high after edge N+2.
//  - Type 11 is delivered unchanged; the consumer ignores it.
//  - No error counters: error outputs are pulses only.
//  - busy_o is 0 in IDLE and 1 in WAIT_LOW, SHIFT and STOP.
// CONFIGURATION
//  CMD_SYNC_EN
//    defined: CMD_i passes through a 2-FF synchronizer (ASYNC_REG) before cmd_q.
//      Adds 2 cycles of latency; cmd_valid_o rises after edge N+4.
//      Synchronizer flops reset to 0.
//    undefined: a single input register; the line is already clk33-synchronous.
// TESTING (CMD_SYNC_EN undefined unless stated)
//  1. DIGITIZE, buffer=2, evid=0x12345678, parity=0, stop=0 -> cmd_valid_o=1 at N+2;
//     type=00, buffer=2, evid=0x12345678; no error pulses.
//  2. Same frame with the parity bit flipped to 1 -> parity_err_o one-cycle pulse;
//     cmd_valid_o stays 0.
//  3. Frame with stop=1 -> frame_err_o pulse; line held high 5 cycles then low, then a valid
//     EVID_RESET frame with evid=0 -> only the second frame is delivered.
//  4. Two good frames back to back with no gap, ack held 0 -> first delivered (evid=1);
//     overrun_o pulses on the second (evid=2); cmd_evid_o stays 1.
//     Repeat with ack=1 in the second STOP cycle -> evid=2 delivered, no overrun.
//  5. rst_n_i low for 3 cycles at bit 20 of a frame, then the line driven high for the
//     remainder -> no delivery and no error until the line goes low; the next good frame is
//     decoded correctly.
//  6. CMD_SYNC_EN defined, test 1 repeated -> identical fields; cmd_valid_o rises exactly
//     2 cycles later than in test 1.

Source files
------------

// File: rtl/surf_cmd_receiver.sv
// surf_cmd_receiver: deframes the per-SURF serial CMD line (one bit per clk33 cycle)
// into type / buffer / event-ID fields, checks even parity and the stop bit, and
// hands good commands to the local digitize/clear logic over a valid/ack handshake.
// Optional build macro CMD_SYNC_EN: inserts a 2-FF synchronizer ahead of cmd_q for
// a CMD line that is not clk33-synchronous (adds 2 cycles of latency).
module surf_cmd_receiver #(
    parameter int BUF_BITS  = 2,
    parameter int EVID_BITS = 32
) (
    input  logic                 clk33_i,
    input  logic                 rst_n_i,
    input  logic                 CMD_i,
    input  logic                 cmd_ack_i,
    output logic                 cmd_valid_o,
    output logic [1:0]           cmd_type_o,
    output logic [BUF_BITS-1:0]  cmd_buffer_o,
    output logic [EVID_BITS-1:0] cmd_evid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    // Bits shifted after the start bit and before the stop bit: type, buffer, evid, parity.
    localparam int SHIFT_LEN = 2 + BUF_BITS + EVID_BITS + 1;
    localparam int CNT_W     = $clog2(SHIFT_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SHIFT_LEN - 1);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        SHIFT    = 2'd2,
        STOP     = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   cmd_in;
    logic                   vld_in;
    logic                   cmd_q;
    logic                   cmd_vld;
    logic [SHIFT_LEN-1:0]   shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   shift_en;
    logic                   cnt_clr;
    logic                   deliver;
    logic                   perr;
    logic                   ferr;
    logic                   parity_bad;

    // Even parity over type, buffer, evid and the parity bit itself.
    function automatic logic parity_fail(input logic [SHIFT_LEN-1:0] bits);
        return ^bits;
    endfunction

`ifdef CMD_SYNC_EN
    (* ASYNC_REG = "TRUE" *) logic cmd_meta;
    (* ASYNC_REG = "TRUE" *) logic cmd_sync;
    logic vld_meta;
    logic vld_sync;

    // Two-flop synchronizer for an asynchronous CMD line; a valid bit travels alongside.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_meta <= 1'b0;
            cmd_sync <= 1'b0;
            vld_meta <= 1'b0;
            vld_sync <= 1'b0;
        end else begin
            cmd_meta <= CMD_i;
            cmd_sync <= cmd_meta;
            vld_meta <= 1'b1;
            vld_sync <= vld_meta;
        end
    end

    assign cmd_in = cmd_sync;
    assign vld_in = vld_sync;
`else
    assign cmd_in = CMD_i;
    assign vld_in = 1'b1;
`endif

    // Input register; cmd_vld marks that cmd_q holds a real line sample, so the
    // reset value of cmd_q cannot be mistaken for the line having gone low.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q   <= 1'b0;
            cmd_vld <= 1'b0;
        end else begin
            cmd_q   <= cmd_in;
            cmd_vld <= vld_in;
        end
    end

    assign parity_bad = parity_fail(shift_reg);

    // FSM state register.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= WAIT_LOW;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        deliver    = 1'b0;
        perr       = 1'b0;
        ferr       = 1'b0;
        case (state)
            WAIT_LOW: begin
                if (cmd_vld && !cmd_q) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (cmd_q) begin
                    cnt_clr    = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (cmd_q) begin
                    // Bad stop bit wins over parity; resync on a low line.
                    ferr       = 1'b1;
                    next_state = WAIT_LOW;
                end else if (parity_bad) begin
                    perr       = 1'b1;
                    next_state = IDLE;
                end else begin
                    deliver    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = WAIT_LOW;
        endcase
    end

    // Bit counter and MSB-first shift register.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[SHIFT_LEN-2:0], cmd_q};
            end
        end
    end

    // Command hand-off, error pulses and busy flag.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_valid_o  <= 1'b0;
            cmd_type_o   <= '0;
            cmd_buffer_o <= '0;
            cmd_evid_o   <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            parity_err_o <= perr;
            frame_err_o  <= ferr;
            overrun_o    <= 1'b0;
            busy_o       <= (next_state != IDLE);
            if (deliver && (!cmd_valid_o || cmd_ack_i)) begin
                cmd_valid_o  <= 1'b1;
                cmd_type_o   <= shift_reg[SHIFT_LEN-1 -: 2];
                cmd_buffer_o <= shift_reg[SHIFT_LEN-3 -: BUF_BITS];
                cmd_evid_o   <= shift_reg[EVID_BITS:1];
            end else begin
                // Pending command is kept; the new one is dropped.
                if (deliver) begin
                    overrun_o <= 1'b1;
                end
                if (cmd_ack_i) begin
                    cmd_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_surf_cmd_receiver.sv
// Testbench for surf_cmd_receiver: table of single frames plus hand-written
// sequences for frame-error resync, back-to-back overrun and mid-frame reset.
module tb_surf_cmd_receiver;

    localparam int BUF_BITS  = 2;
    localparam int EVID_BITS = 32;
    localparam int FLEN      = 1 + 2 + BUF_BITS + EVID_BITS + 1 + 1;
`ifdef CMD_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd = 1'b0;
    logic                 ack = 1'b0;
    logic                 valid;
    logic [1:0]           ctype;
    logic [BUF_BITS-1:0]  cbuf;
    logic [EVID_BITS-1:0] cevid;
    logic                 perr_o;
    logic                 ferr_o;
    logic                 ovr_o;
    logic                 busy;

    surf_cmd_receiver #(.BUF_BITS(BUF_BITS), .EVID_BITS(EVID_BITS)) dut (
        .clk33_i      (clk),
        .rst_n_i      (rst_n),
        .CMD_i        (cmd),
        .cmd_ack_i    (ack),
        .cmd_valid_o  (valid),
        .cmd_type_o   (ctype),
        .cmd_buffer_o (cbuf),
        .cmd_evid_o   (cevid),
        .parity_err_o (perr_o),
        .frame_err_o  (ferr_o),
        .overrun_o    (ovr_o),
        .busy_o       (busy)
    );

    always #15 clk = ~clk;

    int cyc = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int rise_cyc = -1;
    logic valid_prev = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;
    int stop_edge = 0;
    int p0, f0, o0;

    // Posedge counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and valid-rise time, sampled mid-cycle.
    always @(negedge clk) begin
        if (perr_o) perr_cnt <= perr_cnt + 1;
        if (ferr_o) ferr_cnt <= ferr_cnt + 1;
        if (ovr_o)  ovr_cnt  <= ovr_cnt + 1;
        if (valid && !valid_prev) rise_cyc <= cyc;
        valid_prev <= valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]           typ;
        logic [BUF_BITS-1:0]  bufn;
        logic [EVID_BITS-1:0] evid;
        bit                   pflip;
        bit                   stop;
        bit                   exp_valid;
        bit                   exp_perr;
        bit                   exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [FLEN-1:0] mk(input logic [1:0] t, input logic [BUF_BITS-1:0] b,
                                           input logic [EVID_BITS-1:0] e, input bit pflip,
                                           input bit stop);
        logic [2+BUF_BITS+EVID_BITS-1:0] body;
        logic par;
        body = {t, b, e};
        par  = (^body) ^ pflip;
        return {1'b1, body, par, stop};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame MSB first; returns right after the stop bit is placed on the line.
    task automatic send(input logic [FLEN-1:0] f);
        for (int i = FLEN - 1; i >= 0; i--) begin
            @(negedge clk);
            cmd = f[i];
        end
        stop_edge = cyc + 1;
    endtask

    task automatic snap();
        p0 = perr_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
    endtask

    task automatic ack_clear(input string nm);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({nm, "_cleared"}, 64'(valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{2'b00, 2'd2, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 2'd2, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 2'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 2'd3, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b00, 2'd0, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 2'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state.
        tick(3);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_fields", {30'd0, ctype, cbuf, cevid}, 64'd0);
        chk("rst_pulses", {61'd0, perr_o, ferr_o, ovr_o}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick(4);
        chk("idle_busy", 64'(busy), 64'd0);

        // Ack with nothing pending is ignored.
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        chk("stray_ack_valid", 64'(valid), 64'd0);

        // Table of single frames.
        for (int v = 0; v < 6; v++) begin
            snap();
            send(mk(vecs[v].typ, vecs[v].bufn, vecs[v].evid, vecs[v].pflip, vecs[v].stop));
            @(negedge clk);
            cmd = 1'b0;
            tick(6);
            chk($sformatf("v%0d_perr", v), 64'(perr_cnt - p0), 64'(vecs[v].exp_perr));
            chk($sformatf("v%0d_ferr", v), 64'(ferr_cnt - f0), 64'(vecs[v].exp_ferr));
            chk($sformatf("v%0d_ovr", v), 64'(ovr_cnt - o0), 64'd0);
            chk($sformatf("v%0d_valid", v), 64'(valid), 64'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("v%0d_type", v), 64'(ctype), 64'(vecs[v].typ));
                chk($sformatf("v%0d_buf", v), 64'(cbuf), 64'(vecs[v].bufn));
                chk($sformatf("v%0d_evid", v), 64'(cevid), 64'(vecs[v].evid));
                chk($sformatf("v%0d_latency", v), 64'(rise_cyc - stop_edge), 64'(LAT));
                ack_clear($sformatf("v%0d", v));
            end
        end

        // Bad stop bit, line held high, then a good EVID_RESET frame.
        snap();
        send(mk(2'b00, 2'd2, 32'h12345678, 1'b0, 1'b1));
        repeat (5) begin
            @(negedge clk);
            cmd = 1'b1;
        end
        chk("ferr_hold_busy", 64'(busy), 64'd1);
        chk("ferr_hold_cnt", 64'(ferr_cnt - f0), 64'd1);
        chk("ferr_hold_valid", 64'(valid), 64'd0);
        @(negedge clk);
        cmd = 1'b0;
        tick(4);
        chk("ferr_resync_busy", 64'(busy), 64'd0);
        send(mk(2'b10, 2'd0, 32'h0, 1'b0, 1'b0));
        @(negedge clk);
        cmd = 1'b0;
        tick(5);
        chk("ferr_next_valid", 64'(valid), 64'd1);
        chk("ferr_next_type", 64'(ctype), 64'd2);
        chk("ferr_next_evid", 64'(cevid), 64'd0);
        chk("ferr_next_errs", 64'((ferr_cnt - f0) * 16 + (perr_cnt - p0)), 64'h10);
        ack_clear("ferr_next");

        // Back to back, no ack: second frame overruns.
        snap();
        send(mk(2'b00, 2'd0, 32'd1, 1'b0, 1'b0));
        send(mk(2'b00, 2'd0, 32'd2, 1'b0, 1'b0));
        @(negedge clk);
        cmd = 1'b0;
        tick(5);
        chk("b2b_valid", 64'(valid), 64'd1);
        chk("b2b_evid", 64'(cevid), 64'd1);
        chk("b2b_ovr", 64'(ovr_cnt - o0), 64'd1);
        chk("b2b_errs", 64'((perr_cnt - p0) + (ferr_cnt - f0)), 64'd0);
        ack_clear("b2b");

        // Back to back, ack during the second STOP cycle: second frame replaces first.
        snap();
        send(mk(2'b00, 2'd0, 32'd1, 1'b0, 1'b0));
        send(mk(2'b00, 2'd0, 32'd2, 1'b0, 1'b0));
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            cmd = 1'b0;
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        tick(3);
        chk("b2b_ack_valid", 64'(valid), 64'd1);
        chk("b2b_ack_evid", 64'(cevid), 64'd2);
        chk("b2b_ack_ovr", 64'(ovr_cnt - o0), 64'd0);
        ack_clear("b2b_ack");

        // Reset in the middle of a frame with the line then held high.
        snap();
        begin
            logic [FLEN-1:0] f;
            f = mk(2'b01, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0);
            for (int i = FLEN - 1; i >= FLEN - 20; i--) begin
                @(negedge clk);
                cmd = f[i];
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        cmd   = 1'b1;
        tick(2);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(20);
        chk("midrst_hold_busy", 64'(busy), 64'd1);
        chk("midrst_hold_valid", 64'(valid), 64'd0);
        chk("midrst_hold_errs", 64'((perr_cnt - p0) + (ferr_cnt - f0)), 64'd0);
        @(negedge clk);
        cmd = 1'b0;
        tick(5);
        chk("midrst_low_busy", 64'(busy), 64'd0);
        send(mk(2'b01, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0));
        @(negedge clk);
        cmd = 1'b0;
        tick(5);
        chk("midrst_next_valid", 64'(valid), 64'd1);
        chk("midrst_next_type", 64'(ctype), 64'd1);
        chk("midrst_next_buf", 64'(cbuf), 64'd1);
        chk("midrst_next_evid", 64'(cevid), 64'hDEADBEEF);
        chk("midrst_next_errs", 64'((perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0)), 64'd0);
        ack_clear("midrst_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
